seq_data_compare: RTL and testbench

//  Parametrised multi-cycle magnitude comparator for wide operands, with cascade input.
//  - Captures A, B and a cascade code on a start strobe.
//  - Compares one SLICE-bit slice per clock, MSB slice first, and stops at the first differing slice.
//  - Supports unsigned or two's-complement mode.
//  - Successor to the 4-bit cascadable comparator; sits between operand registers and the datapath control FSM.

---
 rtl/cmp_pkg.sv | 12 +
 rtl/data_compare_slice.sv | 14 +
 rtl/seq_data_compare.sv | 101 ++++++++++
 tb/tb_seq_data_compare.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared result codes, FSM encoding and helpers for the sequential magnitude comparator.
package cmp_pkg;
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic is_onehot3(input logic [2:0] code);
        return (code == CMP_GT) || (code == CMP_EQ) || (code == CMP_LT);
    endfunction
endpackage

// File: rtl/data_compare_slice.sv
// Combinational unsigned magnitude compare of one SLICE-bit slice.
module data_compare_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] sliceA,
    input  logic [SLICE-1:0] sliceB,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    assign gt = sliceA >  sliceB;
    assign eq = sliceA == sliceB;
    assign lt = sliceA <  sliceB;
endmodule

// File: rtl/seq_data_compare.sv
// Multi-cycle wide comparator: walks SLICE-bit slices MSB first, stops at the first
// difference, and falls back to a cascade code when all slices match.
module seq_data_compare
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    input  logic [2:0]       iData,
    output logic [2:0]       oData,
    output logic             oBusy,
    output logic             oDone
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : gBadWidth
        $error("seq_data_compare: WIDTH must be a non-zero multiple of SLICE");
    end

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] regA, regB;
    logic             regSigned;
    logic [2:0]       regCas;
    logic [SLICE-1:0] sliceA, sliceB;
    logic             sGt, sEq, sLt;

    // Flipping the sign bit on the top slice maps two's-complement order onto unsigned order.
    always_comb begin
        sliceA = SLICE'(regA >> (int'(idx) * SLICE));
        sliceB = SLICE'(regB >> (int'(idx) * SLICE));
        if (regSigned && (idx == IDX_TOP)) begin
            sliceA[SLICE-1] = ~sliceA[SLICE-1];
            sliceB[SLICE-1] = ~sliceB[SLICE-1];
        end
    end

    data_compare_slice #(.SLICE(SLICE)) uSlice (
        .sliceA (sliceA),
        .sliceB (sliceB),
        .gt     (sGt),
        .eq     (sEq),
        .lt     (sLt)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= IDLE;
            idx       <= IDX_TOP;
            regA      <= '0;
            regB      <= '0;
            regSigned <= 1'b0;
            regCas    <= 3'b000;
            oData     <= 3'b000;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        regA      <= iData_a;
                        regB      <= iData_b;
                        regSigned <= iSigned;
                        regCas    <= iData;
                        idx       <= IDX_TOP;
                        state     <= RUN;
                        oBusy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (!sEq) begin
                        oData <= sGt ? CMP_GT : CMP_LT;
                        oDone <= 1'b1;
                        oBusy <= 1'b0;
                        state <= IDLE;
                    end else if (idx == '0) begin
                        oData <= is_onehot3(regCas) ? regCas : CMP_EQ;
                        oDone <= 1'b1;
                        oBusy <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unusedLt;
    assign unusedLt = sLt;
endmodule

// File: tb/tb_seq_data_compare.sv
// Directed bench for seq_data_compare (WIDTH=16, SLICE=4): vector table plus corner sequences.
module tb_seq_data_compare;
    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iStart = 1'b0;
    logic        iSigned = 1'b0;
    logic [15:0] iData_a = '0;
    logic [15:0] iData_b = '0;
    logic [2:0]  iData = 3'b010;
    logic [2:0]  oData;
    logic        oBusy;
    logic        oDone;

    int errors = 0;
    int checks = 0;

    seq_data_compare #(.WIDTH(16), .SLICE(4)) dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iStart  (iStart),
        .iSigned (iSigned),
        .iData_a (iData_a),
        .iData_b (iData_b),
        .iData   (iData),
        .oData   (oData),
        .oBusy   (oBusy),
        .oDone   (oDone)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sgn;
        logic [2:0]  cas;
        logic [2:0]  expData;
        int          expLat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a start before edge E0, release it after E0.
    task automatic startCmp(input logic [15:0] a, input logic [15:0] b, input logic sgn, input logic [2:0] cas);
        @(negedge iClk);
        iData_a = a; iData_b = b; iSigned = sgn; iData = cas; iStart = 1'b1;
        @(posedge iClk);
        #1 iStart = 1'b0;
    endtask

    // Count edges after E0 until oDone, bounded.
    task automatic waitDone(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(posedge iClk);
            #1 lat++;
            if (oDone) break;
        end
    endtask

    int lat;

    initial begin
        vecs[0] = '{16'h8000, 16'h0001, 1'b0, 3'b010, 3'b100, 1};
        vecs[1] = '{16'h1234, 16'h1234, 1'b0, 3'b001, 3'b001, 4};
        vecs[2] = '{16'h1234, 16'h1234, 1'b0, 3'b000, 3'b010, 4};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 3'b010, 3'b001, 1};
        vecs[4] = '{16'hFFFF, 16'hFFFE, 1'b1, 3'b010, 3'b100, 4};
        vecs[5] = '{16'h0010, 16'h0020, 1'b0, 3'b010, 3'b001, 3};
        vecs[6] = '{16'h1234, 16'h1234, 1'b0, 3'b110, 3'b010, 4};
        vecs[7] = '{16'h1234, 16'h1234, 1'b0, 3'b100, 3'b100, 4};
        vecs[8] = '{16'h7FFF, 16'h8000, 1'b1, 3'b010, 3'b100, 1};
        vecs[9] = '{16'h0005, 16'h0003, 1'b0, 3'b001, 3'b100, 4};

        #12;
        check("reset oData", 32'(oData), 32'h0);
        check("reset oBusy", 32'(oBusy), 32'h0);
        check("reset oDone", 32'(oDone), 32'h0);
        @(negedge iClk);
        iRst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            startCmp(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].cas);
            check($sformatf("vec%0d busy after start", i), 32'(oBusy), 32'h1);
            waitDone(lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
            check($sformatf("vec%0d oData", i), 32'(oData), 32'(vecs[i].expData));
            check($sformatf("vec%0d busy at done", i), 32'(oBusy), 32'h0);
            @(posedge iClk);
            #1;
            check($sformatf("vec%0d done pulse clears", i), 32'(oDone), 32'h0);
            check($sformatf("vec%0d oData holds", i), 32'(oData), 32'(vecs[i].expData));
        end

        // Start during RUN with new operands must be ignored.
        startCmp(16'h0005, 16'h0003, 1'b0, 3'b010);
        @(negedge iClk);
        iData_a = 16'h0000; iData_b = 16'hFFFF; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(posedge iClk);
            #1 lat++;
            if (oDone) break;
        end
        check("ignored start latency", 32'(lat), 32'd4);
        check("ignored start oData", 32'(oData), 32'h4);

        // Back-to-back: start accepted in the oDone cycle, oData not cleared.
        startCmp(16'h8000, 16'h0001, 1'b0, 3'b010);
        waitDone(lat);
        check("b2b first latency", 32'(lat), 32'd1);
        iData_a = 16'h0010; iData_b = 16'h0020; iStart = 1'b1;
        @(posedge iClk);
        #1 iStart = 1'b0;
        check("b2b busy", 32'(oBusy), 32'h1);
        check("b2b done low", 32'(oDone), 32'h0);
        check("b2b oData kept", 32'(oData), 32'h4);
        waitDone(lat);
        check("b2b second latency", 32'(lat), 32'd3);
        check("b2b second oData", 32'(oData), 32'h1);

        // Async reset mid-RUN, between edges.
        startCmp(16'h1234, 16'h1234, 1'b0, 3'b100);
        @(posedge iClk);
        #3 iRst_n = 1'b0;
        #1;
        check("midrun reset oBusy", 32'(oBusy), 32'h0);
        check("midrun reset oData", 32'(oData), 32'h0);
        check("midrun reset oDone", 32'(oDone), 32'h0);
        lat = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge iClk);
            #1 if (oDone) lat++;
        end
        check("no done after abort", 32'(lat), 32'd0);
        @(negedge iClk);
        iRst_n = 1'b1;
        startCmp(16'h0010, 16'h0020, 1'b0, 3'b010);
        waitDone(lat);
        check("post reset latency", 32'(lat), 32'd3);
        check("post reset oData", 32'(oData), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
